// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the clocked SR latch bank.
package sr_latch_pkg;

  // Policy a channel applies when both accepted levels are high.
  typedef enum logic [1:0] {
    SR_RST_DOM = 2'b00,
    SR_SET_DOM = 2'b01,
    SR_HOLD    = 2'b10,
    SR_TOGGLE  = 2'b11
  } sr_mode_e;

  // Filter counter width, sized for the largest allowed FILTER_CYCLES (16).
  localparam int unsigned SR_CNT_W = $clog2(16) + 1;

endpackage

// File: rtl/sr_latch_cell.sv
// One set/reset channel: input synchroniser, glitch filter, state, conflict flag, change pulse.
module sr_latch_cell
  import sr_latch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter sr_mode_e    MODE          = SR_RST_DOM,
  parameter logic        INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic clr,
  input  logic clr_conflict,
  output logic q,
  output logic qn,
  output logic chg,
  output logic conflict
);

  localparam logic [SR_CNT_W-1:0] FILT_CNT = SR_CNT_W'(FILTER_CYCLES);

  logic s_sync;
  logic r_sync;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_sync = s;
    assign r_sync = r;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] s_sync_q, s_sync_d;
    logic [SYNC_STAGES-1:0] r_sync_q, r_sync_d;

    // Shift raw inputs through the synchroniser chain; clr leaves it alone.
    always_comb begin
      s_sync_d    = s_sync_q << 1;
      s_sync_d[0] = s;
      r_sync_d    = r_sync_q << 1;
      r_sync_d[0] = r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_sync_q <= '0;
        r_sync_q <= '0;
      end else begin
        s_sync_q <= s_sync_d;
        r_sync_q <= r_sync_d;
      end
    end

    assign s_sync = s_sync_q[SYNC_STAGES-1];
    assign r_sync = r_sync_q[SYNC_STAGES-1];
  end

  logic                sf_q, sf_d, rf_q, rf_d;
  logic [SR_CNT_W-1:0] cnt_s_q, cnt_s_d, cnt_s_inc;
  logic [SR_CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_r_inc;
  logic                q_q, q_d;
  logic                chg_q, chg_d;
  logic                conflict_q, conflict_d;
  logic                both_d;

  // Filter, state policy and flags; the toggle fires only on entry into "both".
  always_comb begin
    sf_d      = sf_q;
    rf_d      = rf_q;
    cnt_s_d   = '0;
    cnt_r_d   = '0;
    cnt_s_inc = cnt_s_q + SR_CNT_W'(1);
    cnt_r_inc = cnt_r_q + SR_CNT_W'(1);

    if (s_sync != sf_q) begin
      if (cnt_s_inc == FILT_CNT) sf_d = ~sf_q;
      else                       cnt_s_d = cnt_s_inc;
    end
    if (r_sync != rf_q) begin
      if (cnt_r_inc == FILT_CNT) rf_d = ~rf_q;
      else                       cnt_r_d = cnt_r_inc;
    end

    both_d = sf_d & rf_d;
    q_d    = q_q;
    if (sf_d && !rf_d) begin
      q_d = 1'b1;
    end else if (rf_d && !sf_d) begin
      q_d = 1'b0;
    end else if (both_d) begin
      case (MODE)
        SR_RST_DOM: q_d = 1'b0;
        SR_SET_DOM: q_d = 1'b1;
        SR_HOLD:    q_d = q_q;
        SR_TOGGLE:  q_d = (sf_q & rf_q) ? q_q : ~q_q;
        default:    q_d = q_q;
      endcase
    end

    conflict_d = conflict_q;
    if (both_d)            conflict_d = 1'b1;
    else if (clr_conflict) conflict_d = 1'b0;

    chg_d = (q_d != q_q);

    if (clr) begin
      sf_d       = 1'b0;
      rf_d       = 1'b0;
      cnt_s_d    = '0;
      cnt_r_d    = '0;
      q_d        = INIT;
      conflict_d = 1'b0;
      chg_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf_q       <= 1'b0;
      rf_q       <= 1'b0;
      cnt_s_q    <= '0;
      cnt_r_q    <= '0;
      q_q        <= INIT;
      chg_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sf_q       <= sf_d;
      rf_q       <= rf_d;
      cnt_s_q    <= cnt_s_d;
      cnt_r_q    <= cnt_r_d;
      q_q        <= q_d;
      chg_q      <= chg_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign qn       = ~q_q;
  assign chg      = chg_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N independent clocked SR channels with per-channel S=R=1 policy.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int unsigned    N             = 4,
  parameter int unsigned    SYNC_STAGES   = 2,
  parameter int unsigned    FILTER_CYCLES = 1,
  parameter logic [2*N-1:0] MODE          = '0,
  parameter logic [N-1:0]   INIT          = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  input  logic         clr,
  input  logic [N-1:0] clr_conflict,
  output logic [N-1:0] q,
  output logic [N-1:0] qn,
  output logic [N-1:0] chg,
  output logic [N-1:0] conflict
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    sr_latch_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .MODE         (sr_mode_e'(MODE[2*i+1 -: 2])),
      .INIT         (INIT[i])
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .s           (s[i]),
      .r           (r[i]),
      .clr         (clr),
      .clr_conflict(clr_conflict[i]),
      .q           (q[i]),
      .qn          (qn[i]),
      .chg         (chg[i]),
      .conflict    (conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_sr_latch_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] sa, ra, cca;
  logic       clra;
  logic [3:0] qa, qna, chga, confa;
  logic [3:0] sb, rb, ccb;
  logic       clrb;
  logic [3:0] qb, qnb, chgb, confb;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Slow filtered instance: 2 sync stages, 3-cycle filter.
  sr_latch_bank #(
    .N(4), .SYNC_STAGES(2), .FILTER_CYCLES(3),
    .MODE(8'b11_10_01_00), .INIT(4'b1010)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s(sa), .r(ra), .clr(clra),
    .clr_conflict(cca), .q(qa), .qn(qna), .chg(chga), .conflict(confa)
  );

  // Fast instance: already-synchronous inputs, immediate acceptance.
  sr_latch_bank #(
    .N(4), .SYNC_STAGES(0), .FILTER_CYCLES(1),
    .MODE(8'b11_10_01_00), .INIT(4'b0000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .s(sb), .r(rb), .clr(clrb),
    .clr_conflict(ccb), .q(qb), .qn(qnb), .chg(chgb), .conflict(confb)
  );

  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] q;
    logic [3:0] chg;
    logic [3:0] conf;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input bit sel, input logic [3:0] q,
                      input logic [3:0] chg, input logic [3:0] conf, input string name);
    exp_t e;
    e.cyc = c; e.sel = sel; e.q = q; e.chg = chg; e.conf = conf; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  exp_t        m_e;
  logic [15:0] m_got, m_want;

  // Monitor: check every entry due this cycle; entries left behind count as failures.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e = exp_q.pop_front();
      checks++;
      if (m_e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", m_e.name, m_e.cyc, cyc);
      end else begin
        m_got  = m_e.sel ? {qb, qnb, chgb, confb} : {qa, qna, chga, confa};
        m_want = {m_e.q, ~m_e.q, m_e.chg, m_e.conf};
        if (m_got !== m_want) begin
          failures++;
          $display("FAIL %s @%0d: got q=%b qn=%b chg=%b conflict=%b, expected q=%b qn=%b chg=%b conflict=%b",
                   m_e.name, cyc, m_got[15:12], m_got[11:8], m_got[7:4], m_got[3:0],
                   m_want[15:12], m_want[11:8], m_want[7:4], m_want[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    sa = '0; ra = '0; cca = '0; clra = 1'b0;
    sb = '0; rb = '0; ccb = '0; clrb = 1'b0;

    // Reset values
    tick(3);
    rst_n = 1'b1;
    push(cyc, 0, 4'b1010, 4'b0000, 4'b0000, "A_reset");
    push(cyc, 1, 4'b0000, 4'b0000, 4'b0000, "B_reset");
    tick(2);

    // Latency of a held s[0]; 2-cycle r[1] pulse is filtered away
    c = cyc;
    sa = 4'b0001; ra = 4'b0010;
    push(c + 4, 0, 4'b1010, 4'b0000, 4'b0000, "A_latency_before");
    push(c + 5, 0, 4'b1011, 4'b0001, 4'b0000, "A_latency_edge");
    push(c + 6, 0, 4'b1011, 4'b0000, 4'b0000, "A_latency_after");
    tick(2);
    ra = 4'b0000;
    tick(5);
    sa = 4'b0000;
    tick(6);

    // Global clr while s[0] is half counted restarts the filter
    c = cyc;
    sa = 4'b0000;
    push(c + 3, 0, 4'b1011, 4'b0000, 4'b0000, "A_clr_before");
    push(c + 4, 0, 4'b1010, 4'b0000, 4'b0000, "A_clr_applied");
    push(c + 5, 0, 4'b1010, 4'b0000, 4'b0000, "A_clr_restart1");
    push(c + 6, 0, 4'b1010, 4'b0000, 4'b0000, "A_clr_restart2");
    push(c + 7, 0, 4'b1011, 4'b0001, 4'b0000, "A_clr_accept");
    push(c + 8, 0, 4'b1011, 4'b0000, 4'b0000, "A_clr_settled");
    // q[0] is 1 from the latency test, s[0] was released; rearm it
    sa = 4'b0001;
    tick(3);
    clra = 1'b1;
    tick(1);
    clra = 1'b0;
    tick(4);
    sa = 4'b0000;
    tick(6);

    // Asynchronous reset mid-cycle, observed before the next edge
    c = cyc;
    rst_n = 1'b0;
    push(c, 0, 4'b1010, 4'b0000, 4'b0000, "A_async_reset");
    tick(2);
    rst_n = 1'b1;
    push(cyc, 0, 4'b1010, 4'b0000, 4'b0000, "A_after_reset");
    tick(2);

    // Modes under S=R=1, conflict flag clear, toggle re-entry, global clr
    c = cyc;
    sb = 4'b0101;
    push(c + 1,  1, 4'b0101, 4'b0101, 4'b0000, "B_preset");
    push(c + 2,  1, 4'b0101, 4'b0000, 4'b0000, "B_preset_hold");
    push(c + 3,  1, 4'b1110, 4'b1011, 4'b1111, "B_both_enter");
    push(c + 4,  1, 4'b1110, 4'b0000, 4'b1111, "B_both_persist");
    push(c + 6,  1, 4'b1110, 4'b0000, 4'b1111, "B_clrconf_setwins");
    push(c + 7,  1, 4'b1110, 4'b0000, 4'b1111, "B_both_end");
    push(c + 8,  1, 4'b1110, 4'b0000, 4'b1111, "B_release");
    push(c + 9,  1, 4'b1110, 4'b0000, 4'b1110, "B_clrconf_done");
    push(c + 10, 1, 4'b0110, 4'b1000, 4'b1110, "B_tog_r_only");
    push(c + 11, 1, 4'b1110, 4'b1000, 4'b1110, "B_tog_both1");
    push(c + 12, 1, 4'b1110, 4'b0000, 4'b1110, "B_tog_hold");
    push(c + 13, 1, 4'b0110, 4'b1000, 4'b1110, "B_tog_r_again");
    push(c + 14, 1, 4'b1110, 4'b1000, 4'b1110, "B_tog_both2");
    push(c + 15, 1, 4'b0000, 4'b0000, 4'b0000, "B_global_clr");
    push(c + 16, 1, 4'b0000, 4'b0000, 4'b0000, "B_after_clr");
    tick(1);
    sb = 4'b0000;
    tick(1);
    sb = 4'b1111; rb = 4'b1111;
    tick(3);
    ccb = 4'b0001;
    tick(1);
    ccb = 4'b0000;
    tick(1);
    sb = 4'b0000; rb = 4'b0000;
    tick(1);
    ccb = 4'b0001;
    tick(1);
    ccb = 4'b0000;
    sb = 4'b0000; rb = 4'b1000;
    tick(1);
    sb = 4'b1000;
    tick(2);
    sb = 4'b0000;
    tick(1);
    sb = 4'b1000;
    tick(1);
    sb = 4'b0000; rb = 4'b0000; clrb = 1'b1;
    tick(1);
    clrb = 1'b0;
    tick(2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expected entries never checked", exp_q.size());
      failures += exp_q.size();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised, clocked successor to the cross-coupled NOR SR latch: N independent set/reset channels, each with an input synchroniser, a glitch filter and a per-channel policy for the S=R=1 case that the bare latch leaves undefined. Each channel drives complementary outputs, a one-cycle change pulse and a sticky conflict flag. It sits between asynchronous status/fault pins and synchronous control logic, replacing free-running latch pairs.

## Interface
- N, 4: channel count, 1..32
- SYNC_STAGES, 2: synchroniser flops per input, 0..3; 0 means inputs are already synchronous
- FILTER_CYCLES, 1: consecutive cycles a new level must persist before it is accepted, 1..16
- MODE, {N{2'b00}}: 2 bits per channel, bits [2i+1:2i]; 00 reset-dominant, 01 set-dominant, 10 hold, 11 toggle
- INIT, {N{1'b0}}: per-channel reset and clear value of q

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- s  in  N  set request per channel, level, may be asynchronous
- r  in  N  reset request per channel, level, may be asynchronous
- clr  in  1  synchronous global clear
- clr_conflict  in  N  synchronous per-channel conflict-flag clear
- q  out  N  latched state
- qn  out  N  always ~q
- chg  out  N  one-cycle pulse, high in the first cycle q shows a new value
- conflict  out  N  sticky flag: S and R were both accepted high

## Operation
- Per channel: raw s/r → SYNC_STAGES flops → filter → state logic → q.
- Filter: keeps accepted level sf/rf and a counter. Counter increments while the synchronised input differs from the accepted level, and clears when they match. When the next-counter value would reach FILTER_CYCLES, the accepted level flips and the counter clears. FILTER_CYCLES=1 accepts every new sample immediately.
- State update uses the next accepted levels (sf', rf'):
  - sf'&~rf': q←1
  - rf'&~sf': q←0
  - neither: hold
  - both, mode 00: q←0
  - both, mode 01: q←1
  - both, mode 10: hold
  - both, mode 11: toggle once, on the cycle "both" becomes true; hold while it persists. Re-entering "both" toggles again.
- conflict[i] sets on any cycle with sf'&rf'. If set and clr_conflict[i] occur together, set wins. Otherwise clr_conflict[i] clears the flag.
- chg[i] = registered (q_next != q). No pulse on reset or clr.
- clr: q←INIT, sf/rf←0, counters←0, conflict←0, chg←0. Synchroniser flops are untouched. clr overrides all channel activity that cycle.
- Reset (asynchronous, any time, including mid-filter): q=INIT, qn=~INIT, chg=0, conflict=0, all synchroniser, filter and counter state 0.

## Timing
- Latency: a level first sampled at edge k changes q (and raises chg) after edge k+SYNC_STAGES+FILTER_CYCLES−1, provided it is held stably for that long.
- A pulse shorter than FILTER_CYCLES cycles post-synchroniser is discarded without any output activity.
- s and r changing on the same edge are filtered independently. Whether the "both" case occurs depends on the accepted levels, not the raw pins.
- Release from reset is not synchronised internally. The integrator deasserts rst_n synchronously to clk.
- All outputs are registered and there are no combinational input→output paths. qn is a plain inverter on q.

## Structure
- Package sr_latch_pkg:
  - sr_mode_e enum (SR_RST_DOM, SR_SET_DOM, SR_HOLD, SR_TOGGLE)
  - filter counter width constant: $clog2(16)+1
- Sub-module sr_latch_cell: one channel (synchroniser, filter, state, conflict, chg), with parameters SYNC_STAGES, FILTER_CYCLES, MODE (sr_mode_e) and INIT (1 bit).
- Top: generate loop over N, slicing the MODE and INIT vectors.

## Test plan
- Reset: N=4, INIT=4'b1010, rst_n low mid-stream → q=1010, qn=0101, chg=0, conflict=0 asynchronously, before the next edge.
- Latency: SYNC_STAGES=2, FILTER_CYCLES=3, s[0] held high from edge 10 → q[0]=1 and chg[0]=1 after edge 14 only; chg[0]=0 after edge 15. A 2-cycle s[1] pulse → no change on q[1].
- Modes with S=R=1 held 5 cycles, MODE=8'b11_10_01_00, q=0101 beforehand:
  - ch0 → 0
  - ch1 → 1
  - ch2 → stays 1
  - ch3 → toggles once to 1 and stays
  - conflict=1111
- Toggle re-entry: ch3 both→r only→both, FILTER_CYCLES=1, SYNC_STAGES=0 → q[3] sequence 1,0,1, with chg pulsing each time.
- Flag clear: clr_conflict[0] with S=R still high → conflict[0] stays 1. Clear after release → 0.
- Global clr: during a half-counted filter → q=INIT, counters restart, and the input needs a full FILTER_CYCLES to be accepted afterwards; no chg pulse from clr itself.
